// File: rtl/mv_result_packer.sv
// mv_result_packer
// Collects consecutive scalar results from the dot-product tree into packed
// NUM-lane rows. Completed rows go into a small first-word-fall-through FIFO.
// afull warns the upstream issue logic. overflow records any row that was
// dropped because the FIFO was full.
module mv_result_packer #(
  parameter int NUM       = 16,
  parameter int DW        = 32,
  parameter int DEPTH     = 4,
  parameter int AF_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM*DW-1:0]          out_data,
  output logic [$clog2(NUM+1)-1:0]   out_count,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       afull,
  output logic                       overflow
);

  localparam int CW = $clog2(NUM + 1);
  localparam int LW = $clog2(NUM);
  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Row assembly
  // ---------------------------------------------------------------------------
  logic [LW-1:0]     lane_cnt_reg;
  logic [LW-1:0]     lane_cnt_next;
  logic [NUM*DW-1:0] row_reg;
  logic [NUM*DW-1:0] row_next;
  logic [NUM*DW-1:0] push_row;
  logic              last_lane;
  logic              flush_close;
  logic              push;
  logic [CW-1:0]     push_count;

  // The row as it stands this cycle, including the incoming scalar.
  // This value is what gets pushed when the row closes in the same cycle.
  // Lanes that have not been filled yet are still zero in row_reg.
  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_lane
      assign push_row[gi*DW +: DW] = (in_valid && (lane_cnt_reg == LW'(gi)))
                                     ? in_data
                                     : row_reg[gi*DW +: DW];
    end
  endgenerate

  // Decide when a row closes and how many lanes it holds.
  // A full row and a flush in the same cycle still produce only one push.
  always_comb begin
    last_lane     = in_valid && (lane_cnt_reg == LW'(NUM - 1));
    flush_close   = flush && ((lane_cnt_reg != '0) || in_valid);
    push          = last_lane || flush_close;
    push_count    = last_lane ? CW'(NUM) : (CW'(lane_cnt_reg) + CW'(in_valid));
    lane_cnt_next = lane_cnt_reg;
    row_next      = push_row;
    if (push) begin
      lane_cnt_next = '0;
      row_next      = '0;
    end else if (in_valid) begin
      lane_cnt_next = lane_cnt_reg + LW'(1);
    end
  end

  // Assembly state: lane pointer and the partially filled row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_reg <= '0;
      row_reg      <= '0;
    end else begin
      lane_cnt_reg <= lane_cnt_next;
      row_reg      <= row_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Row FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [NUM*DW-1:0] mem_data  [DEPTH];
  logic [CW-1:0]     mem_count [DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [FW-1:0]     fill_reg;
  logic [FW-1:0]     fill_next;
  logic              afull_reg;
  logic              overflow_reg;
  logic              full;
  logic              pop;
  logic              fifo_wr;
  logic              drop;

  // A push into a full FIFO is accepted only if the head leaves in the same cycle.
  // Otherwise the row is discarded.
  always_comb begin
    full      = (fill_reg == FW'(DEPTH));
    pop       = out_valid && out_ready;
    fifo_wr   = push && (!full || pop);
    drop      = push && full && !pop;
    fill_next = fill_reg + FW'(fifo_wr) - FW'(pop);
  end

  // Row storage. It has no reset because the output is gated while the FIFO is empty.
  // When the FIFO is full, the write slot is the slot being popped, which is safe:
  // the head is read combinationally before the clock edge.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr_reg]  <= push_row;
      mem_count[wr_ptr_reg] <= push_count;
    end
  end

  // Pointers, occupancy, almost-full and sticky overflow.
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      fill_reg     <= '0;
      afull_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (fifo_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      fill_reg  <= fill_next;
      afull_reg <= (fill_next >= FW'(DEPTH - AF_MARGIN));
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Head of the FIFO, forced to zero whenever nothing is queued.
  always_comb begin
    out_valid = (fill_reg != '0);
    out_data  = out_valid ? mem_data[rd_ptr_reg]  : '0;
    out_count = out_valid ? mem_count[rd_ptr_reg] : '0;
    fill      = fill_reg;
    afull     = afull_reg;
    overflow  = overflow_reg;
  end

endmodule
